// File: rtl/ridecore_dmem_arbiter.sv
// ridecore_dmem_arbiter
//
// Two-port arbiter for the single data-memory port of the simulation
// memory model. Port 0 is the core load/store unit. Port 1 is a secondary
// master, such as a fuzz injector or a debug port.
//
// At most one request is granted per cycle. The grant is combinational
// (zero-cycle ready). Read data from the memory model arrives one cycle
// after the request is sampled, and it is steered back to the port that
// issued the read.
//
// Configuration macro:
//   RIDECORE_DMEM_ARB_FIXED_PRIO_EN
//     defined   : port 0 always wins a conflict (strict priority)
//     undefined : round-robin on conflict, using last_grant
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   reqN_valid/ready           request handshake for port N (N = 0, 1)
//   reqN_addr/wdata/we         request payload for port N
//   respN_valid/data           read response for port N
//   dmem_req_addr/data/write_en
//                              request to the memory model
//   dmem_resp_data             read data from the memory model
module ridecore_dmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic              req0_we,
  output logic              resp0_valid,
  output logic [DATA_W-1:0] resp0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  input  logic              req1_we,
  output logic              resp1_valid,
  output logic [DATA_W-1:0] resp1_data,
  output logic [ADDR_W-1:0] dmem_req_addr,
  output logic [DATA_W-1:0] dmem_req_data,
  output logic              dmem_req_write_en,
  input  logic [DATA_W-1:0] dmem_resp_data
);

  typedef enum logic [1:0] {IDLE, PEND0, PEND1} rd_pend_e;

  rd_pend_e          rd_pend_q, rd_pend_d;
  logic              last_grant_q, last_grant_d;
  logic [ADDR_W-1:0] addr_hold_q, addr_hold_d;
  logic              grant0, grant1;

  // Winner selection. Nothing is granted while reset is asserted.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
`ifdef RIDECORE_DMEM_ARB_FIXED_PRIO_EN
    grant0 = req0_valid;
`else
    // On a conflict, port 0 wins only if port 1 had the last grant.
    grant0 = req0_valid && (!req1_valid || last_grant_q);
`endif
    grant1 = req1_valid && !grant0;
    if (reset) begin
      grant0 = 1'b0;
      grant1 = 1'b0;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // Memory drive. When idle, the last granted address is held so that the
  // model sees no new address. Write enable and data are zeroed when idle.
  always_comb begin
    dmem_req_addr     = addr_hold_q;
    dmem_req_data     = '0;
    dmem_req_write_en = 1'b0;
    if (grant0) begin
      dmem_req_addr     = req0_addr;
      dmem_req_data     = req0_wdata;
      dmem_req_write_en = req0_we;
    end else if (grant1) begin
      dmem_req_addr     = req1_addr;
      dmem_req_data     = req1_wdata;
      dmem_req_write_en = req1_we;
    end
  end

  // Next-state logic. Only a read grant creates a pending response.
  always_comb begin
    rd_pend_d    = IDLE;
    last_grant_d = last_grant_q;
    addr_hold_d  = addr_hold_q;
    if (grant0) begin
      last_grant_d = 1'b0;
      addr_hold_d  = req0_addr;
      if (!req0_we) rd_pend_d = PEND0;
    end else if (grant1) begin
      last_grant_d = 1'b1;
      addr_hold_d  = req1_addr;
      if (!req1_we) rd_pend_d = PEND1;
    end
  end

  // Reset drops any response that is in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_pend_q    <= IDLE;
      last_grant_q <= 1'b1;
      addr_hold_q  <= '0;
    end else begin
      rd_pend_q    <= rd_pend_d;
      last_grant_q <= last_grant_d;
      addr_hold_q  <= addr_hold_d;
    end
  end

  // Responses: the valid flags decode the registered state. The data
  // passes straight through from the memory model.
  assign resp0_valid = (rd_pend_q == PEND0);
  assign resp1_valid = (rd_pend_q == PEND1);
  assign resp0_data  = dmem_resp_data;
  assign resp1_data  = dmem_resp_data;

endmodule
